// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer:
// slice width, FSM state encoding and index-width helper.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Nibble index width; at least one bit even for a single-nibble operand.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response handshake bundle between the host and the add/sub sequencer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req_valid, op_a, op_b, op_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, op_a, op_b, op_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_rca4.sv
// Shared 4-bit ripple-carry adder slice built from full adders; also exposes
// the carry into bit 3 so the caller can derive signed overflow.
module nibble_rca4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];
  assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that time-shares one 4-bit adder slice across WIDTH-bit operands,
// one nibble per cycle LSB-first, with a valid/ready request and response.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus,
  output logic                    busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = idx_width(NSLICE);

  logic [1:0]                           state_q;
  logic [1:0]                           state_d;
  logic [IDX_W-1:0]                     idx_q;
  logic                                 carry_q;
  logic [NSLICE-1:0][SLICE_W-1:0]       a_q;
  logic [NSLICE-1:0][SLICE_W-1:0]       b_q;
  logic [NSLICE-1:0][SLICE_W-1:0]       sum_q;
  logic                                 rsp_valid_q;
  logic                                 rsp_cout_q;
  logic                                 rsp_ovf_q;

  logic                                 accept_c;
  logic                                 last_c;
  logic                                 ovf_c;
  logic [SLICE_W-1:0]                   slice_s;
  logic                                 slice_cout;
  logic                                 slice_c3;

  assign bus.req_ready = (state_q == ST_IDLE) && rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

  assign accept_c = bus.req_valid && bus.req_ready;
  assign last_c   = (idx_q == IDX_W'(NSLICE - 1));
  // Carry into the MSB differing from carry out of it is signed overflow.
  assign ovf_c    = slice_c3 ^ slice_cout;

  nibble_rca4 u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)       state_d = ST_RUN;
      ST_RUN:  if (last_c)         state_d = ST_DONE;
      ST_DONE: if (bus.rsp_ready)  state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Operand capture, nibble stepping and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b ^ {WIDTH{bus.op_sub}};
            carry_q <= bus.op_sub;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q[idx_q] <= slice_s;
          carry_q      <= slice_cout;
          if (last_c) begin
            rsp_valid_q <= 1'b1;
            rsp_cout_q  <= slice_cout;
            rsp_ovf_q   <= ovf_c;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for the nibble-serial add/sub sequencer at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_add_ctrl;

  logic clk;
  logic rst_n16;
  logic rst_n4;
  logic busy16;
  logic busy4;
  int   n_cmp;
  int   n_fail;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) if16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(4))  if4 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n16),
    .bus   (if16.slave),
    .busy  (busy16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n4),
    .bus   (if4.slave),
    .busy  (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub);
    if16.op_a      = a;
    if16.op_b      = b;
    if16.op_sub    = sub;
    if16.req_valid = 1'b1;
    chk("req_ready16_before_accept", 32'(if16.req_ready), 32'd1);
    step();
    if16.req_valid = 1'b0;
    chk("busy16_after_accept", 32'(busy16), 32'd1);
  endtask

  task automatic wait16(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!if16.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic rsp16(input string tag, input logic [15:0] s, input logic c, input logic o);
    chk({tag, "_sum"},  32'(if16.rsp_sum),  32'(s));
    chk({tag, "_cout"}, 32'(if16.rsp_cout), 32'(c));
    chk({tag, "_ovf"},  32'(if16.rsp_ovf),  32'(o));
  endtask

  task automatic pop16();
    if16.rsp_ready = 1'b1;
    step();
    if16.rsp_ready = 1'b0;
    chk("rsp_valid16_after_pop", 32'(if16.rsp_valid), 32'd0);
    chk("req_ready16_after_pop", 32'(if16.req_ready), 32'd1);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] s, input logic c, input logic o);
    issue16(a, b, sub);
    wait16({tag, "_latency"}, 4);
    rsp16(tag, s, c, o);
    pop16();
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic sub, input logic [3:0] s, input logic c, input logic o);
    int lat;
    if4.op_a      = a;
    if4.op_b      = b;
    if4.op_sub    = sub;
    if4.req_valid = 1'b1;
    chk({tag, "_req_ready"}, 32'(if4.req_ready), 32'd1);
    step();
    if4.req_valid = 1'b0;
    lat = 0;
    while (!if4.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    chk({tag, "_sum"},  32'(if4.rsp_sum),  32'(s));
    chk({tag, "_cout"}, 32'(if4.rsp_cout), 32'(c));
    chk({tag, "_ovf"},  32'(if4.rsp_ovf),  32'(o));
    if4.rsp_ready = 1'b1;
    step();
    if4.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clr"}, 32'(if4.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rsub;
    logic [3:0] bx;
    logic [4:0] full;
    int         sa;
    int         sb;
    int         sr;

    n_cmp  = 0;
    n_fail = 0;
    if16.req_valid = 1'b0;
    if16.op_a      = '0;
    if16.op_b      = '0;
    if16.op_sub    = 1'b0;
    if16.rsp_ready = 1'b0;
    if4.req_valid  = 1'b0;
    if4.op_a       = '0;
    if4.op_b       = '0;
    if4.op_sub     = 1'b0;
    if4.rsp_ready  = 1'b0;
    rst_n16 = 1'b0;
    rst_n4  = 1'b0;
    step();
    step();
    chk("req_ready16_in_reset", 32'(if16.req_ready), 32'd0);
    rst_n16 = 1'b1;
    rst_n4  = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(if16.rsp_valid), 32'd0);
    chk("reset_rsp_sum",   32'(if16.rsp_sum),   32'd0);
    chk("reset_rsp_cout",  32'(if16.rsp_cout),  32'd0);
    chk("reset_rsp_ovf",   32'(if16.rsp_ovf),   32'd0);
    chk("reset_busy",      32'(busy16),         32'd0);
    chk("reset_req_ready", 32'(if16.req_ready), 32'd1);

    op16("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    op16("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op16("sub_0003_0005", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: response held, new request ignored.
    issue16(16'h1234, 16'h1111, 1'b0);
    wait16("hold_latency", 4);
    if16.req_valid = 1'b1;
    if16.op_a      = 16'hFFFF;
    if16.op_b      = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rsp_valid", 32'(if16.rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(if16.req_ready), 32'd0);
      rsp16("hold", 16'h2345, 1'b0, 1'b0);
    end
    if16.req_valid = 1'b0;
    pop16();
    chk("hold_no_second_accept_busy", 32'(busy16), 32'd0);
    step();
    chk("hold_idle_after_pop", 32'(busy16), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    issue16(16'h0F0F, 16'h0101, 1'b0);
    step();
    rst_n16 = 1'b0;
    step();
    chk("abort_rsp_valid", 32'(if16.rsp_valid), 32'd0);
    chk("abort_busy",      32'(busy16),         32'd0);
    rst_n16 = 1'b1;
    #1;
    chk("abort_req_ready_after_release", 32'(if16.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_response", 32'(if16.rsp_valid), 32'd0);
    end
    op16("post_abort_add", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // WIDTH=4 instance.
    op4("w4_add_9_8", 4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
    op4("w4_sub_2_3", 4'h2, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      rsub = 1'($urandom_range(0, 1));
      bx   = rsub ? ~rb : rb;
      full = 5'(ra) + 5'(bx) + 5'(rsub);
      sa   = (ra >= 4'd8) ? int'(ra) - 16 : int'(ra);
      sb   = (rb >= 4'd8) ? int'(rb) - 16 : int'(rb);
      sr   = rsub ? sa - sb : sa + sb;
      op4("w4_random", ra, rb, rsub, full[3:0], full[4], (sr > 7) || (sr < -8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
